// File: rtl/multiword_addsub_seq.sv
// multiword_addsub_seq: wide add/sub computed one SIZE-bit word per cycle through a shared ripple slice
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module multiword_addsub_seq #(
  parameter int SIZE  = 4,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  sub,
  input  logic [SIZE*WORDS-1:0] a,
  input  logic [SIZE*WORDS-1:0] b,
  output logic                  busy,
  output logic                  done,
  output logic [SIZE*WORDS-1:0] result,
  output logic                  cout,
  output logic                  ovf
);
  localparam int N  = SIZE * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [N-1:0]    a_q, b_q;
  logic            sub_q, carry_q;
  logic [IW-1:0]   idx;
  logic [SIZE-1:0] a_w, b_w, s_w;
  logic [SIZE:0]   c;

  // Word 0 takes sub as carry-in so subtraction becomes a + ~b + 1 across the full width
  assign a_w  = a_q[idx*SIZE +: SIZE];
  assign b_w  = b_q[idx*SIZE +: SIZE] ^ {SIZE{sub_q}};
  assign c[0] = (idx == '0) ? sub_q : carry_q;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    full_adder u_fa (.a(a_w[i]), .b(b_w[i]), .ci(c[i]), .s(s_w[i]), .co(c[i+1]));
  end

  // Control FSM: capture operands, walk the words LSB first, then pulse done for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      idx     <= '0;
      carry_q <= 1'b0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_q    <= a;
            b_q    <= b;
            sub_q  <= sub;
            idx    <= '0;
            result <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            busy   <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          result[idx*SIZE +: SIZE] <= s_w;
          carry_q <= c[SIZE];
          if (idx == IW'(WORDS - 1)) begin
            cout  <= c[SIZE];
            ovf   <= c[SIZE] ^ c[SIZE-1];
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_multiword_addsub_seq.sv
// tb_multiword_addsub_seq: directed and random checks of the sequential wide add/sub
module tb_multiword_addsub_seq;
  localparam int SIZE  = 4;
  localparam int WORDS = 4;
  localparam int N     = SIZE * WORDS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [N-1:0] a = '0;
  logic [N-1:0] b = '0;
  logic         busy, done, cout, ovf;
  logic [N-1:0] result;

  int checks = 0;
  int errors = 0;

  multiword_addsub_seq #(.SIZE(SIZE), .WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference computed with plain integer arithmetic on the full-width values
  function automatic void model(input logic [15:0] x, input logic [15:0] y, input logic s,
                                output logic [15:0] r, output logic co, output logic ov);
    int ur, sr;
    ur = s ? (int'(x) - int'(y)) : (int'(x) + int'(y));
    sr = s ? (int'($signed(x)) - int'($signed(y))) : (int'($signed(x)) + int'($signed(y)));
    r  = ur[15:0];
    co = s ? (x >= y) : (ur > 65535);
    ov = (sr > 32767) || (sr < -32768);
  endfunction

  // Runs one operation; scrambles inputs right after capture to prove they are latched
  task automatic run_op(input logic [15:0] oa, input logic [15:0] ob, input logic os,
                        output logic [15:0] r, output logic co, output logic ov);
    int n;
    @(negedge clk);
    a = oa; b = ob; sub = os; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    chk("busy_after_start", 32'(busy), 1);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!done && n < 20);
    chk("done_latency", n, WORDS);
    r = result; co = cout; ov = ovf;
    @(posedge clk); #1;
    chk("busy_low_after_done", 32'(busy), 0);
    chk("done_one_cycle", 32'(done), 0);
  endtask

  task automatic dir(input string tag, input logic [15:0] oa, input logic [15:0] ob, input logic os,
                     input logic [15:0] er, input logic eco, input logic eov);
    logic [15:0] r;
    logic co, ov;
    run_op(oa, ob, os, r, co, ov);
    chk({tag, "_result"}, 32'(r), 32'(er));
    chk({tag, "_cout"}, 32'(co), 32'(eco));
    chk({tag, "_ovf"}, 32'(ov), 32'(eov));
  endtask

  initial begin
    logic [15:0] r, mr, ra, rb;
    logic co, ov, mco, mov, rs;
    int pulses, last;
    logic [15:0] seen_r;
    #2;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_cout", 32'(cout), 0);
    chk("rst_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    dir("add", 16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0, 1'b0);
    dir("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    dir("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    dir("sub_borrow", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    dir("sub_ovf", 16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    dir("sub_eq", 16'h1234, 16'h1234, 1'b1, 16'h0000, 1'b1, 1'b0);

    // Start pulse during RUN must be ignored
    @(negedge clk);
    a = 16'h0001; b = 16'h0001; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    a = 16'h1111; b = 16'h2222; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    pulses = 0; seen_r = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin pulses++; seen_r = result; end
      @(posedge clk); #1;
    end
    chk("ignore_start_pulses", pulses, 1);
    chk("ignore_start_result", 32'(seen_r), 32'h0002);

    // Held start repeats every WORDS+2 cycles
    @(negedge clk);
    a = 16'h0102; b = 16'h0304; sub = 1'b0; start = 1'b1;
    pulses = 0; last = -1;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk); #1;
      if (done) begin
        if (last >= 0) chk("hold_period", i - last, WORDS + 2);
        chk("hold_result", 32'(result), 32'h0406);
        last = i;
        pulses++;
      end
    end
    chk("hold_pulse_count", 32'(pulses >= 3), 1);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && busy; i++) @(negedge clk);
    chk("hold_idle", 32'(busy), 0);

    // Asynchronous reset two cycles into RUN aborts without a done pulse
    @(negedge clk);
    a = 16'h1234; b = 16'h4321; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_result", 32'(result), 0);
    chk("abort_cout", 32'(cout), 0);
    chk("abort_ovf", 32'(ovf), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done || busy) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    dir("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
      if (i % 8 == 0) rb = ra;
      run_op(ra, rb, rs, r, co, ov);
      model(ra, rb, rs, mr, mco, mov);
      chk("rand_result", 32'(r), 32'(mr));
      chk("rand_cout", 32'(co), 32'(mco));
      chk("rand_ovf", 32'(ov), 32'(mov));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multiword_addsub_seq.md
# multiword_addsub_seq

Sequential controller that computes a wide add or subtract by reusing one SIZE-bit ripple add/sub slice over WORDS cycles, least-significant word first. It holds the inter-word carry in a register. Full operand width is SIZE*WORDS. The block sits between a requester using a start/done handshake and the narrow adder datapath, trading latency for area.

## Interface
Parameters:
- SIZE, default 4: width of one word and of the internal adder slice.
- WORDS, default 4: number of words per operand; must be ≥ 1. Full width N = SIZE*WORDS.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request; sampled only in IDLE.
- sub  input  1  operation select: 0 = a+b, 1 = a−b.
- a  input  N  operand A; unsigned or two's complement.
- b  input  N  operand B.
- busy  output  1  high whenever the state is not IDLE.
- done  output  1  one-cycle pulse; result, cout and ovf are valid.
- result  output  N  sum or difference, modulo 2^N.
- cout  output  1  carry out of bit N−1; for sub, 1 means no borrow (a ≥ b unsigned).
- ovf  output  1  signed overflow of the full-width operation.

## Operation
- Datapath:
  - One SIZE-bit slice built from full_adder cells; the slice's b input is b_word XOR sub.
  - Slice carry-in is sub on word 0, and the carry register on words 1..WORDS−1.
- Registers:
  - a_q, b_q, sub_q: captured operands.
  - idx: word index, width max(1, clog2(WORDS)).
  - carry_q
  - result, cout, ovf, state.
- State IDLE:
  - busy=0, done=0.
  - If start=1: capture a, b and sub; set idx=0; clear result to 0; go to RUN.
- State RUN:
  - Each cycle, word idx = a_q[idx*SIZE +: SIZE] and b_q[idx*SIZE +: SIZE] is computed and written into result[idx*SIZE +: SIZE].
  - carry_q is loaded with the slice carry-out.
  - If idx == WORDS−1:
    - cout = slice carry-out.
    - ovf = (carry into slice MSB) XOR (slice carry-out).
    - Go to DONE.
  - Otherwise idx increments.
- State DONE:
  - done=1 for exactly one cycle; go to IDLE unconditionally.
  - start is ignored in DONE.
- start, a, b and sub are ignored while busy=1. Changes to a, b and sub after capture do not affect the operation in progress.
- result, cout and ovf hold their values from the DONE cycle until the next accepted start. result is cleared on accept; cout and ovf are cleared on accept.
- WORDS=1: RUN lasts one cycle, and the slice carry-in is sub.
- Reset (any time, including mid-RUN):
  - state=IDLE, idx=0, carry_q=0.
  - result=0, cout=0, ovf=0, busy=0, done=0.
  - No done pulse is issued for an aborted operation.
  - The first start after reset deasserts behaves normally.

## Timing
- Let start be sampled high in IDLE at rising edge T.
  - busy is high from just after T.
  - Word k is written at edge T+1+k, for k = 0..WORDS−1.
  - At edge T+WORDS, state becomes DONE; done, cout and ovf are valid during the cycle after that edge.
  - At edge T+WORDS+1, state becomes IDLE and busy is low.
- The earliest next start is sampled at edge T+WORDS+2.
  - If start is held high, operations repeat every WORDS+2 cycles.
- result bits for words already processed are visible mid-operation. They are not guaranteed valid until done.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
All scenarios use SIZE=4, WORDS=4 (N=16).
- Add 0x1234 + 0x0FFF, sub=0 → result=0x2233, cout=0, ovf=0, done exactly 4 edges after start is sampled, busy low one cycle later.
- Full ripple: 0xFFFF + 0x0001 → result=0x0000, cout=1, ovf=0. Also 0x7FFF + 0x0001 → result=0x8000, cout=0, ovf=1.
- Subtract:
  - 0x0005 − 0x0007 → result=0xFFFE, cout=0, ovf=0.
  - 0x8000 − 0x0001 → result=0x7FFF, cout=1, ovf=1.
  - 0x1234 − 0x1234 → result=0x0000, cout=1, ovf=0.
- Handshake:
  - Pulse start with a=0x1111, b=0x2222 during RUN of a 0x0001+0x0001 operation → result=0x0002, and only one done pulse.
  - Hold start high with fixed operands → done pulses every 6 cycles.
- Reset mid-operation: assert rst_n=0 asynchronously two cycles into RUN → busy, done, result, cout and ovf go to 0 immediately and no done follows. After release, 0x00FF + 0x0001 → result=0x0100, cout=0.
- Operand change after capture: change a, b and sub on the cycle after start → result reflects the captured values only.
